weight_ram_loader: RTL and testbench

- Write-side companion to the conv-layer weight address generator.
- Accepts a serial weight stream over a valid/ready handshake and packs consecutive words into even/odd pairs.
- Writes each pair into the dual-port weight RAM in a single cycle: port A gets the even address, port B gets address+1. This fills exactly the layout the read-side generator later walks.
- Sits between the off-chip or host weight stream and the weight RAM. Runs once per layer, triggered by start.

---
 rtl/weight_ram_loader.sv | 99 +++++++++
 tb/tb_weight_ram_loader.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/weight_ram_loader.sv
// Packs a serial weight stream into even/odd word pairs and writes each pair
// into the dual-port weight RAM in one cycle (port A even address, port B odd).
module weight_ram_loader #(
  parameter int DATA_WIDTH          = 16,
  parameter int WEIGHT_ADDR_WIDTH   = 10,
  parameter int NUM_ONE_PIXEL_CYCLE = 26,
  parameter int NUM_ONEMULT         = 2,
  localparam int TOTAL_WORDS        = 2 * NUM_ONE_PIXEL_CYCLE * NUM_ONEMULT,
  localparam int CNT_W              = $clog2(TOTAL_WORDS + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         s_valid,
  input  logic [DATA_WIDTH-1:0]        s_data,
  output logic                         s_ready,
  output logic                         wea,
  output logic                         web,
  output logic [WEIGHT_ADDR_WIDTH-1:0] addra,
  output logic [WEIGHT_ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0]        dina,
  output logic [DATA_WIDTH-1:0]        dinb,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(TOTAL_WORDS - 1);

  state_t                         state, state_nxt;
  logic [CNT_W-1:0]               cnt;
  logic [WEIGHT_ADDR_WIDTH-1:0]   base;
  logic [DATA_WIDTH-1:0]          hold;
  logic                           hold_valid;
  logic                           accept;
  logic                           restart;

  assign s_ready = (state == LOAD);
  assign busy    = (state == LOAD);
  assign done    = (state == DONE);
  assign accept  = s_valid && s_ready;
  assign restart = start && (state != LOAD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (accept && cnt == LAST_WORD) state_nxt = DONE;
      DONE:    if (start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes pulse for one cycle; address/data registers keep their last write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      base       <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      wea        <= 1'b0;
      web        <= 1'b0;
      addra      <= '0;
      addrb      <= WEIGHT_ADDR_WIDTH'(1);
      dina       <= '0;
      dinb       <= '0;
    end else begin
      wea <= 1'b0;
      web <= 1'b0;
      if (restart) begin
        cnt        <= '0;
        base       <= '0;
        hold_valid <= 1'b0;
      end else if (accept) begin
        cnt <= cnt + CNT_W'(1);
        if (!hold_valid) begin
          hold       <= s_data;
          hold_valid <= 1'b1;
        end else begin
          wea        <= 1'b1;
          web        <= 1'b1;
          addra      <= base;
          addrb      <= base + WEIGHT_ADDR_WIDTH'(1);
          dina       <= hold;
          dinb       <= s_data;
          base       <= base + WEIGHT_ADDR_WIDTH'(2);
          hold_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_weight_ram_loader.sv
// Randomized bench for weight_ram_loader: a stream-level model predicts every
// RAM write (word k lands at address k) and the handshake/status outputs.
module tb_weight_ram_loader;

  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int TOTAL = 104;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready, wea, web, busy, done;
  logic [AW-1:0] addra, addrb;
  logic [DW-1:0] dina, dinb;

  logic          c_start, c_valid;
  logic [DW-1:0] c_data;
  logic          c_ready, c_wea, c_web, c_busy, c_done;
  logic [AW-1:0] c_addra, c_addrb;
  logic [DW-1:0] c_dina, c_dinb;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: phase 0 idle, 1 loading, 2 finished
  int            m_phase;
  int            m_nacc;
  logic [DW-1:0] words[$];
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_d0, m_d1;
  int            m_strobes;

  always #5 clk = ~clk;

  weight_ram_loader dut (
    .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .wea(wea), .web(web), .addra(addra), .addrb(addrb),
    .dina(dina), .dinb(dinb), .busy(busy), .done(done)
  );

  weight_ram_loader #(.NUM_ONE_PIXEL_CYCLE(1), .NUM_ONEMULT(1)) dut_c (
    .clk(clk), .reset(reset), .start(c_start), .s_valid(c_valid), .s_data(c_data),
    .s_ready(c_ready), .wea(c_wea), .web(c_web), .addra(c_addra), .addrb(c_addrb),
    .dina(c_dina), .dinb(c_dinb), .busy(c_busy), .done(c_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_nacc = 0; words.delete();
    m_addr = '0; m_d0 = '0; m_d1 = '0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".s_ready"}, 32'(s_ready), 0);
    chk({tag, ".wea"},     32'(wea), 0);
    chk({tag, ".web"},     32'(web), 0);
    chk({tag, ".addra"},   32'(addra), 0);
    chk({tag, ".addrb"},   32'(addrb), 1);
    chk({tag, ".dina"},    32'(dina), 0);
    chk({tag, ".dinb"},    32'(dinb), 0);
    chk({tag, ".busy"},    32'(busy), 0);
    chk({tag, ".done"},    32'(done), 0);
  endtask

  // One clock: drive at negedge, check s_ready, then check registered outputs after the edge.
  task automatic step(input logic st, input logic v, input logic [DW-1:0] d);
    logic acc, exp_we;
    @(negedge clk);
    start = st; s_valid = v; s_data = d;
    #1;
    chk("s_ready", 32'(s_ready), 32'(m_phase == 1));
    acc = v && (m_phase == 1);
    @(posedge clk); #1;
    exp_we = 1'b0;
    if (m_phase != 1 && st) begin
      m_phase = 1; m_nacc = 0; words.delete();
    end else if (acc) begin
      words.push_back(d);
      m_nacc++;
      if (m_nacc % 2 == 0) begin
        exp_we = 1'b1;
        m_addr = AW'(m_nacc - 2);
        m_d0   = words[m_nacc-2];
        m_d1   = d;
        m_strobes++;
      end
      if (m_nacc == TOTAL) m_phase = 2;
    end
    chk("wea",   32'(wea),   32'(exp_we));
    chk("web",   32'(web),   32'(exp_we));
    chk("addra", 32'(addra), 32'(m_addr));
    chk("addrb", 32'(addrb), 32'(m_addr + AW'(1)));
    chk("dina",  32'(dina),  32'(m_d0));
    chk("dinb",  32'(dinb),  32'(m_d1));
    chk("busy",  32'(busy),  32'(m_phase == 1));
    chk("done",  32'(done),  32'(m_phase == 2));
  endtask

  // Full load: stream words base_val+k; bubbly mode adds random gaps and stray starts.
  task automatic load(input int base_val, input bit bubbly, input int stop_at);
    int idx, cycles;
    logic v, st;
    m_strobes = 0;
    step(1'b1, 1'b0, '0);
    idx = 0; cycles = 0;
    while (m_phase == 1 && m_nacc < stop_at && cycles < 2000) begin
      v  = bubbly ? ($urandom_range(0, 2) != 0) : 1'b1;
      st = bubbly ? ($urandom_range(0, 7) == 0) : 1'b0;
      step(st, v, DW'(base_val + idx));
      if (v) idx++;
      cycles++;
    end
    chk("load_timeout", 32'(cycles < 2000), 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
    c_start = 1'b0; c_valid = 1'b0; c_data = '0;
    model_reset();
    #1;
    chk_reset_outputs("reset");
    @(negedge clk); reset = 1'b0;

    // s_valid in IDLE is ignored
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, DW'(16'hdead));

    // Basic back-to-back fill
    load(0, 1'b0, TOTAL);
    chk("basic.strobes", 32'(m_strobes), TOTAL / 2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, DW'(16'hbeef));

    // Reload with gaps and stray starts
    load(1000, 1'b1, TOTAL);
    chk("bubbly.strobes", 32'(m_strobes), TOTAL / 2);

    // Abort mid-load with an odd word pending
    load(0, 1'b1, 37);
    @(negedge clk);
    s_valid = 1'b1; reset = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    model_reset();
    @(negedge clk); reset = 1'b0;
    step(1'b0, 1'b1, '0);
    load(2000, 1'b0, TOTAL);
    chk("after_reset.strobes", 32'(m_strobes), TOTAL / 2);
    step(1'b0, 1'b0, '0);

    // Two-word parameter corner
    @(negedge clk); c_start = 1'b1;
    @(posedge clk); #1;
    chk("c.busy", 32'(c_busy), 1);
    @(negedge clk); c_start = 1'b0; c_valid = 1'b1; c_data = 16'h0005;
    #1;
    chk("c.s_ready", 32'(c_ready), 1);
    @(posedge clk); #1;
    chk("c.wea_early", 32'(c_wea), 0);
    @(negedge clk); c_data = 16'h0006;
    @(posedge clk); #1;
    chk("c.wea",   32'(c_wea), 1);
    chk("c.web",   32'(c_web), 1);
    chk("c.addra", 32'(c_addra), 0);
    chk("c.addrb", 32'(c_addrb), 1);
    chk("c.dina",  32'(c_dina), 5);
    chk("c.dinb",  32'(c_dinb), 6);
    chk("c.done",  32'(c_done), 1);
    chk("c.busy0", 32'(c_busy), 0);
    @(negedge clk); c_valid = 1'b0;
    @(posedge clk); #1;
    chk("c.wea_end",  32'(c_wea), 0);
    chk("c.done_hold", 32'(c_done), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
